load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Sits between the MEM-stage pipeline controls and the word-wide data memory, whose read is combinational and whose write is synchronous and whole-word only. It converts RISC-V load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses. Sub-word stores are done as a two-cycle read-modify-write. Loads get a registered, sign- or zero-extended result. Misaligned and out-of-range accesses are flagged and never reach memory.

Parameters:
MEM_BYTES, 4096, addressable data-memory size in bytes; addresses >= MEM_BYTES are out of range.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
MemRead  in  1  load request this cycle
MemWrite  in  1  store request this cycle
funct3  in  3  RISC-V width/sign code of the access
address  in  32  byte address from the ALU
store_data  in  32  rs2 value; low byte or half used for SB/SH
stall  out  1  hold pipeline; request inputs must stay stable while high
load_result  out  32  registered, extended load data
load_valid  out  1  one-cycle pulse: load_result updated
access_err  out  1  one-cycle pulse: misaligned, out-of-range or illegal funct3
dm_address  out  32  word-aligned address to data memory (low 2 bits = 0)
dm_write_data  out  32  full word to data memory
dm_MemWrite  out  1  data-memory write enable
dm_MemRead  out  1  data-memory read qualifier
dm_read_data  in  32  combinational read word from data memory

Behaviour:
- Reset (async): state=IDLE; stall, load_valid, access_err, dm_MemWrite and dm_MemRead all 0; load_result=0. Reset asserted mid-RMW cancels the write in the same cycle.
- Byte order is little-endian: lane k = dm_read_data[8k+7:8k], with k = address[1:0].
- Legality:
  - LW/SW require address[1:0]=0.
  - LH/LHU/SH require address[0]=0.
  - Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010.
  - Any address >= MEM_BYTES is illegal.
  - An illegal request produces no memory write, no load_valid, and access_err=1 on the next cycle. State stays IDLE.
- Simultaneous MemRead and MemWrite: the store is performed and the read is ignored.
- FSM states are IDLE and MERGE.
- IDLE, load: dm_MemRead=1 and dm_address=address&~3. At the posedge, load_result captures the extended lane(s) and load_valid=1 the next cycle. Latency 1, no stall.
- IDLE, SW: dm_MemWrite=1 and dm_write_data=store_data combinationally. The write commits at the posedge. No stall.
- IDLE, SB/SH: dm_MemRead=1 and stall=1.
  - At the posedge: latch the merged word (dm_read_data with the target byte or half replaced by store_data[7:0] or [15:0]) and the word address. Go to MERGE.
- MERGE: dm_address=latched address, dm_write_data=merged word, dm_MemWrite=1, stall=0. Return to IDLE at the posedge. New requests are not sampled in MERGE.
- Sign extension: LB/LH replicate the top bit of the selected lane(s); LBU/LHU zero-fill.
- dm_MemWrite is never asserted for a request flagged illegal.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - the state encoding IDLE/MERGE.
- One combinational sub-module, lsu_lane_align, contains:
  - the load extractor (lane select plus extend);
  - the store merger (old word, new data, offset, size → merged word);
  - the misalignment check.
- The top module holds the FSM, the latches and the out-of-range check.

Test Plan:
- Pre-load mem[0x10]=0x8899AABB. LB @0x12 → load_result=0xFFFFFF99, load_valid pulse one cycle later. Then LBU @0x13 → 0x00000088. Then LHU @0x10 → 0x0000AABB.
- SB @0x11, store_data=0x12345655 → stall=1 for exactly one cycle, dm_MemWrite in the MERGE cycle, mem[0x10]=0x889955BB. Then LH @0x10 → 0x000055BB.
- SW @0x20 with 0xDEADBEEF → no stall. Then LW @0x20 on the next cycle → 0xDEADBEEF.
- SH @0x13 → access_err pulse, dm_MemWrite stays 0, mem unchanged. LW @0x1000 (MEM_BYTES=4096) → access_err, no load_valid.
- Reset asserted during MERGE of an SH @0x14 → dm_MemWrite drops immediately, stall=0, state IDLE, mem[0x14] unchanged.
- MemRead=MemWrite=1 with SW @0x30 of 0xCAFEF00D → mem[0x30]=0xCAFEF00D, no load_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V width codes, FSM states
// and a funct3 legality helper.
package lsu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      IDLE  = 1'b0,
      MERGE = 1'b1
   } lsu_state_e;

   // Stores only come in signed widths; loads add the unsigned variants.
   function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
      if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: load extraction/extension, sub-word store
// merge into the old memory word, and alignment checking.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] rd_word,
   input  logic [XLEN-1:0] store_data,
   output logic [XLEN-1:0] load_data,
   output logic [XLEN-1:0] merged_word,
   output logic            misaligned
);

   logic [4:0]      shamt;
   logic [XLEN-1:0] lane_word;
   logic [XLEN-1:0] mask;

   always_comb begin
      shamt     = {offset, 3'b000};
      lane_word = rd_word >> shamt;

      misaligned = 1'b0;
      case (funct3[1:0])
         2'b10:   misaligned = (offset != 2'b00);
         2'b01:   misaligned = offset[0];
         default: misaligned = 1'b0;
      endcase

      load_data = '0;
      case (funct3)
         F3_B:    load_data = {{24{lane_word[7]}}, lane_word[7:0]};
         F3_H:    load_data = {{16{lane_word[15]}}, lane_word[15:0]};
         F3_W:    load_data = lane_word;
         F3_BU:   load_data = {24'h0, lane_word[7:0]};
         F3_HU:   load_data = {16'h0, lane_word[15:0]};
         default: load_data = '0;
      endcase

      // Mask selects the bytes replaced by the new data; the rest keep the old word.
      case (funct3[1:0])
         2'b00:   mask = 32'h0000_00FF << shamt;
         2'b01:   mask = 32'h0000_FFFF << shamt;
         default: mask = 32'hFFFF_FFFF;
      endcase
      merged_word = (rd_word & ~mask) | ((store_data << shamt) & mask);
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns byte/half/word requests into word accesses,
// with read-modify-write for sub-word stores and registered extended loads.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] address,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic [31:0] load_result,
   output logic        load_valid,
   output logic        access_err,
   output logic [31:0] dm_address,
   output logic [31:0] dm_write_data,
   output logic        dm_MemWrite,
   output logic        dm_MemRead,
   input  logic [31:0] dm_read_data
);

   lsu_state_e state_q, state_d;

   logic [31:0] load_result_q, load_result_d;
   logic [31:0] merge_word_q, merge_word_d;
   logic [31:0] merge_addr_q, merge_addr_d;
   logic        load_valid_q, load_valid_d;
   logic        access_err_q, access_err_d;

   logic [31:0] load_data;
   logic [31:0] merged_word;
   logic [31:0] word_addr;
   logic        misaligned;
   logic        out_of_range;
   logic        illegal;
   logic        in_idle;
   logic        req_any;
   logic        load_ok;
   logic        store_ok;
   logic        sub_store_ok;

   lsu_lane_align u_align (
      .funct3      (funct3),
      .offset      (address[1:0]),
      .rd_word     (dm_read_data),
      .store_data  (store_data),
      .load_data   (load_data),
      .merged_word (merged_word),
      .misaligned  (misaligned)
   );

   // Request qualification; a simultaneous read+write is treated as a store.
   always_comb begin
      word_addr    = {address[31:2], 2'b00};
      out_of_range = (address >= 32'(MEM_BYTES));
      illegal      = misaligned | out_of_range | ~f3_legal(funct3, MemWrite);
      in_idle      = (state_q == IDLE);
      req_any      = MemRead | MemWrite;
      store_ok     = in_idle & MemWrite & ~illegal;
      load_ok      = in_idle & MemRead & ~MemWrite & ~illegal;
      sub_store_ok = store_ok & (funct3 != F3_W);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sub_store_ok) state_d = MERGE;
         MERGE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Memory-side outputs are combinational; reset gates them so an in-flight
   // merge write is cancelled in the cycle reset rises.
   always_comb begin
      stall         = 1'b0;
      dm_MemRead    = 1'b0;
      dm_MemWrite   = 1'b0;
      dm_address    = word_addr;
      dm_write_data = '0;
      case (state_q)
         IDLE: begin
            if (load_ok) begin
               dm_MemRead = 1'b1;
            end else if (sub_store_ok) begin
               dm_MemRead = 1'b1;
               stall      = 1'b1;
            end else if (store_ok) begin
               dm_MemWrite   = 1'b1;
               dm_write_data = store_data;
            end
         end
         MERGE: begin
            dm_address    = merge_addr_q;
            dm_write_data = merge_word_q;
            dm_MemWrite   = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         stall       = 1'b0;
         dm_MemRead  = 1'b0;
         dm_MemWrite = 1'b0;
      end
   end

   always_comb begin
      load_valid_d  = load_ok;
      access_err_d  = in_idle & req_any & illegal;
      load_result_d = load_ok ? load_data : load_result_q;
      merge_word_d  = sub_store_ok ? merged_word : merge_word_q;
      merge_addr_d  = sub_store_ok ? word_addr : merge_addr_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_result_q <= '0;
         load_valid_q  <= 1'b0;
         access_err_q  <= 1'b0;
         merge_word_q  <= '0;
         merge_addr_q  <= '0;
      end else begin
         load_result_q <= load_result_d;
         load_valid_q  <= load_valid_d;
         access_err_q  <= access_err_d;
         merge_word_q  <= merge_word_d;
         merge_addr_q  <= merge_addr_d;
      end
   end

   assign load_result = load_result_q;
   assign load_valid  = load_valid_q;
   assign access_err  = access_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

   logic        clk;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  funct3;
   logic [31:0] address;
   logic [31:0] store_data;
   logic        stall;
   logic [31:0] load_result;
   logic        load_valid;
   logic        access_err;
   logic [31:0] dm_address;
   logic [31:0] dm_write_data;
   logic        dm_MemWrite;
   logic        dm_MemRead;
   logic [31:0] dm_read_data;

   logic [31:0] mem [0:1023];
   logic [31:0] sb_q [$];
   int          checks;
   int          failures;

   load_store_unit #(.MEM_BYTES(4096)) dut (
      .clk           (clk),
      .reset         (reset),
      .MemRead       (MemRead),
      .MemWrite      (MemWrite),
      .funct3        (funct3),
      .address       (address),
      .store_data    (store_data),
      .stall         (stall),
      .load_result   (load_result),
      .load_valid    (load_valid),
      .access_err    (access_err),
      .dm_address    (dm_address),
      .dm_write_data (dm_write_data),
      .dm_MemWrite   (dm_MemWrite),
      .dm_MemRead    (dm_MemRead),
      .dm_read_data  (dm_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign dm_read_data = mem[dm_address[11:2]];

   always @(posedge clk) begin
      if (dm_MemWrite) mem[dm_address[11:2]] <= dm_write_data;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Pop the scoreboard whenever a load result is presented.
   always @(negedge clk) begin
      if (!reset && load_valid) begin
         if (sb_q.size() == 0) check_eq("lv_unexpected", 32'(load_valid), 32'd0);
         else                  check_eq("load_result", load_result, sb_q.pop_front());
      end
      if (dm_MemRead || dm_MemWrite) begin
         check_eq("dm_align", 32'(dm_address[1:0]), 32'd0);
         check_eq("dm_range", 32'(dm_address >= 32'd4096), 32'd0);
      end
   end

   task automatic set_idle();
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      funct3     = 3'b000;
      address    = '0;
      store_data = '0;
   endtask

   task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic exp_err, input logic exp_lv,
                      input logic exp_stall, input logic [31:0] exp_res);
      @(posedge clk);
      #1;
      MemRead    = rd;
      MemWrite   = wr;
      funct3     = f3;
      address    = addr;
      store_data = data;
      if (exp_lv) sb_q.push_back(exp_res);
      #1;
      check_eq("stall", 32'(stall), 32'(exp_stall));
      if (exp_err) check_eq("no_write_illegal", 32'(dm_MemWrite), 32'd0);
      @(posedge clk);
      #1;
      if (exp_stall) begin
         check_eq("merge_we", 32'(dm_MemWrite), 32'd1);
         check_eq("merge_stall", 32'(stall), 32'd0);
         set_idle();
         @(posedge clk);
         #1;
      end else begin
         set_idle();
      end
      check_eq("access_err", 32'(access_err), 32'(exp_err));
      check_eq("load_valid", 32'(load_valid), 32'(exp_lv));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[4]  = 32'h8899_AABB;
      mem[5]  = 32'h1122_3344;
      set_idle();
      reset = 1'b1;
      #2;
      check_eq("rst_stall", 32'(stall), 32'd0);
      check_eq("rst_lv", 32'(load_valid), 32'd0);
      check_eq("rst_err", 32'(access_err), 32'd0);
      check_eq("rst_result", load_result, 32'd0);
      check_eq("rst_we", 32'(dm_MemWrite), 32'd0);
      check_eq("rst_re", 32'(dm_MemRead), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Loads from a pre-loaded word
      req(1, 0, 3'b000, 32'h12, 0, 0, 1, 0, 32'hFFFF_FF99);
      req(1, 0, 3'b100, 32'h13, 0, 0, 1, 0, 32'h0000_0088);
      req(1, 0, 3'b101, 32'h10, 0, 0, 1, 0, 32'h0000_AABB);
      req(1, 0, 3'b001, 32'h12, 0, 0, 1, 0, 32'hFFFF_8899);

      // Sub-word store through read-modify-write
      req(0, 1, 3'b000, 32'h11, 32'h1234_5655, 0, 0, 1, 0);
      check_eq("mem10_sb", mem[4], 32'h8899_55BB);
      req(1, 0, 3'b001, 32'h10, 0, 0, 1, 0, 32'h0000_55BB);

      // Full-word store then readback
      req(0, 1, 3'b010, 32'h20, 32'hDEAD_BEEF, 0, 0, 0, 0);
      check_eq("mem20_sw", mem[8], 32'hDEAD_BEEF);
      req(1, 0, 3'b010, 32'h20, 0, 0, 1, 0, 32'hDEAD_BEEF);

      // Illegal requests
      req(0, 1, 3'b001, 32'h13, 32'hFFFF_FFFF, 1, 0, 0, 0);
      check_eq("mem10_sh_bad", mem[4], 32'h8899_55BB);
      req(1, 0, 3'b010, 32'h1000, 0, 1, 0, 0, 0);
      req(1, 0, 3'b011, 32'h10, 0, 1, 0, 0, 0);
      req(0, 1, 3'b100, 32'h10, 32'h0, 1, 0, 0, 0);
      check_eq("mem10_f3_bad", mem[4], 32'h8899_55BB);
      req(1, 0, 3'b010, 32'hFFC, 0, 0, 1, 0, 32'h0000_0000);

      // Reset lands in the MERGE cycle of an SH
      @(posedge clk);
      #1;
      MemWrite   = 1'b1;
      funct3     = 3'b001;
      address    = 32'h14;
      store_data = 32'h0000_AAAA;
      #1;
      check_eq("rst_mid_stall0", 32'(stall), 32'd1);
      @(posedge clk);
      #1;
      check_eq("rst_mid_we_pre", 32'(dm_MemWrite), 32'd1);
      set_idle();
      reset = 1'b1;
      #1;
      check_eq("rst_mid_we", 32'(dm_MemWrite), 32'd0);
      check_eq("rst_mid_stall", 32'(stall), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      check_eq("mem14_cancel", mem[5], 32'h1122_3344);
      req(1, 0, 3'b010, 32'h14, 0, 0, 1, 0, 32'h1122_3344);

      // Read and write together: store wins, no load result
      req(1, 1, 3'b010, 32'h30, 32'hCAFE_F00D, 0, 0, 0, 0);
      check_eq("mem30_rw", mem[12], 32'hCAFE_F00D);

      repeat (2) @(posedge clk);
      #1;
      check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
